// File: rtl/sdrc_bs_convert_gen.sv
// Application-to-SDRAM bus-width converter: splits 32-bit application words into
// 1/2/4 SDRAM beats on writes and packs read beats back into words.
module sdrc_bs_convert_gen #(
  parameter int APP_AW = 30,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sdr_width,
  input  logic [APP_AW-1:0] app_req_addr,
  output logic [APP_AW+1:0] app_req_addr_int,
  input  logic [APP_RW-1:0] app_req_len,
  output logic [APP_RW+1:0] app_req_len_int,
  input  logic              app_req_wr_n,
  input  logic              app_sdr_req,
  output logic              app_sdr_req_int,
  input  logic              app_req_dma_last,
  output logic              app_req_dma_last_int,
  input  logic              app_req_ack_int,
  output logic              app_req_ack,
  input  logic [APP_DW-1:0] app_wr_data,
  input  logic [APP_BW-1:0] app_wr_en_n,
  output logic [APP_DW-1:0] app_wr_data_int,
  output logic [APP_BW-1:0] app_wr_en_n_int,
  input  logic              app_wr_next_int,
  output logic              app_wr_next,
  input  logic [APP_DW-1:0] app_rd_data_int,
  input  logic              app_rd_valid_int,
  output logic [APP_DW-1:0] app_rd_data,
  output logic              app_rd_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [1:0]        idx;
  logic [APP_RW-1:0] words_left;
  logic [15:0]       rd_buf0;
  logic [7:0]        rd_buf1;
  logic [7:0]        rd_buf2;

  logic [1:0]        shift_in;
  logic [1:0]        last_idx;
  logic              is_last;
  logic              passthru;
  logic              beat;
  logic [APP_RW-1:0] len_eff;

  // Reserved width code 11 behaves as a full 32-bit SDRAM.
  function automatic logic [1:0] width_to_shift(input logic [1:0] w);
    return (w == 2'b11) ? 2'b00 : w;
  endfunction

  function automatic logic [1:0] shift_to_last(input logic [1:0] s);
    case (s)
      2'd1:    return 2'd1;
      2'd2:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign shift_in = width_to_shift(sdr_width);
  assign len_eff  = (app_req_len == '0) ? APP_RW'(1) : app_req_len;

  assign app_req_addr_int     = {2'b00, app_req_addr} << shift_in;
  assign app_req_len_int      = {2'b00, len_eff} << shift_in;
  assign app_req_dma_last_int = app_req_dma_last;
  assign app_req_ack          = app_req_ack_int;
  assign app_sdr_req_int      = app_sdr_req & ~reset & (state == ST_IDLE);

  assign last_idx = shift_to_last(mode_q);
  assign is_last  = (idx == last_idx);
  assign passthru = (state == ST_IDLE) && (mode_q == 2'd0);
  assign beat     = ((state == ST_WR) && app_wr_next_int) ||
                    ((state == ST_RD) && app_rd_valid_int);

  assign app_wr_next  = ~reset & (passthru ? app_wr_next_int
                                           : ((state == ST_WR) & app_wr_next_int & is_last));
  assign app_rd_valid = ~reset & (passthru ? app_rd_valid_int
                                           : ((state == ST_RD) & app_rd_valid_int & is_last));

  // Write beat slicing: narrow beats ride on the LSBs, unused enables stay inactive.
  always_comb begin
    app_wr_data_int = '0;
    app_wr_en_n_int = '1;
    case (mode_q)
      2'd1: begin
        if (idx[0]) begin
          app_wr_data_int[15:0] = app_wr_data[31:16];
          app_wr_en_n_int[1:0]  = app_wr_en_n[3:2];
        end else begin
          app_wr_data_int[15:0] = app_wr_data[15:0];
          app_wr_en_n_int[1:0]  = app_wr_en_n[1:0];
        end
      end
      2'd2: begin
        case (idx)
          2'd0:    app_wr_data_int[7:0] = app_wr_data[7:0];
          2'd1:    app_wr_data_int[7:0] = app_wr_data[15:8];
          2'd2:    app_wr_data_int[7:0] = app_wr_data[23:16];
          default: app_wr_data_int[7:0] = app_wr_data[31:24];
        endcase
        app_wr_en_n_int[0] = app_wr_en_n[idx];
      end
      default: begin
        app_wr_data_int = app_wr_data;
        app_wr_en_n_int = app_wr_en_n;
      end
    endcase
  end

  // Read word assembly: the final beat is used directly, earlier ones come from rd_buf.
  always_comb begin
    app_rd_data = app_rd_data_int;
    case (mode_q)
      2'd1:    app_rd_data = {app_rd_data_int[15:0], rd_buf0};
      2'd2:    app_rd_data = {app_rd_data_int[7:0], rd_buf2, rd_buf1, rd_buf0[7:0]};
      default: app_rd_data = app_rd_data_int;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (app_req_ack_int && (shift_in != 2'd0))
          state_nxt = app_req_wr_n ? ST_RD : ST_WR;
      end
      ST_WR, ST_RD: begin
        if (beat && is_last && (words_left == '0))
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: burst control and read beat buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode_q     <= 2'd0;
      idx        <= 2'd0;
      words_left <= '0;
      rd_buf0    <= '0;
      rd_buf1    <= '0;
      rd_buf2    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && app_req_ack_int) begin
        mode_q     <= shift_in;
        idx        <= 2'd0;
        words_left <= len_eff - APP_RW'(1);
      end else if (beat) begin
        if (is_last) begin
          idx <= 2'd0;
          if (words_left != '0)
            words_left <= words_left - APP_RW'(1);
        end else begin
          idx <= idx + 2'd1;
          if (state == ST_RD) begin
            case (idx)
              2'd0:    rd_buf0 <= app_rd_data_int[15:0];
              2'd1:    rd_buf1 <= app_rd_data_int[7:0];
              default: rd_buf2 <= app_rd_data_int[7:0];
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sdrc_bs_convert_gen.sv
// Directed bench for the bus-width converter: 32/16/8-bit bursts, busy gating,
// mid-burst reset and zero-length requests.
module tb_sdrc_bs_convert_gen;

  localparam int APP_AW = 30;
  localparam int APP_DW = 32;
  localparam int APP_BW = 4;
  localparam int APP_RW = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        sdr_width;
  logic [APP_AW-1:0] app_req_addr;
  logic [APP_AW+1:0] app_req_addr_int;
  logic [APP_RW-1:0] app_req_len;
  logic [APP_RW+1:0] app_req_len_int;
  logic              app_req_wr_n;
  logic              app_sdr_req;
  logic              app_sdr_req_int;
  logic              app_req_dma_last;
  logic              app_req_dma_last_int;
  logic              app_req_ack_int;
  logic              app_req_ack;
  logic [APP_DW-1:0] app_wr_data;
  logic [APP_BW-1:0] app_wr_en_n;
  logic [APP_DW-1:0] app_wr_data_int;
  logic [APP_BW-1:0] app_wr_en_n_int;
  logic              app_wr_next_int;
  logic              app_wr_next;
  logic [APP_DW-1:0] app_rd_data_int;
  logic              app_rd_valid_int;
  logic [APP_DW-1:0] app_rd_data;
  logic              app_rd_valid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdrc_bs_convert_gen #(
    .APP_AW(APP_AW), .APP_DW(APP_DW), .APP_BW(APP_BW), .APP_RW(APP_RW)
  ) dut (
    .clk(clk), .reset(reset), .sdr_width(sdr_width),
    .app_req_addr(app_req_addr), .app_req_addr_int(app_req_addr_int),
    .app_req_len(app_req_len), .app_req_len_int(app_req_len_int),
    .app_req_wr_n(app_req_wr_n), .app_sdr_req(app_sdr_req),
    .app_sdr_req_int(app_sdr_req_int), .app_req_dma_last(app_req_dma_last),
    .app_req_dma_last_int(app_req_dma_last_int), .app_req_ack_int(app_req_ack_int),
    .app_req_ack(app_req_ack), .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_data_int(app_wr_data_int), .app_wr_en_n_int(app_wr_en_n_int),
    .app_wr_next_int(app_wr_next_int), .app_wr_next(app_wr_next),
    .app_rd_data_int(app_rd_data_int), .app_rd_valid_int(app_rd_valid_int),
    .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ack_req(input logic [1:0] w, input logic [APP_AW-1:0] a,
                         input logic [APP_RW-1:0] l, input logic wr_n);
    sdr_width = w; app_req_addr = a; app_req_len = l; app_req_wr_n = wr_n;
    app_sdr_req = 1'b1; app_req_ack_int = 1'b1;
    tick();
    app_sdr_req = 1'b0; app_req_ack_int = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sdr_width = 2'b00; app_req_addr = '0; app_req_len = '0;
    app_req_wr_n = 1'b1; app_sdr_req = 1'b1; app_req_dma_last = 1'b1;
    app_req_ack_int = 1'b0; app_wr_data = '0; app_wr_en_n = '1;
    app_wr_next_int = 1'b1; app_rd_data_int = '0; app_rd_valid_int = 1'b1;
    tick(); tick();
    settle();
    check("rst_req_int", app_sdr_req_int, 1'b0);
    check("rst_wr_next", app_wr_next, 1'b0);
    check("rst_rd_valid", app_rd_valid, 1'b0);
    check("rst_dma_last", app_req_dma_last_int, 1'b1);

    reset = 1'b0; app_wr_next_int = 1'b0; app_rd_valid_int = 1'b0;
    app_req_dma_last = 1'b0;
    tick();

    // 32-bit write, length 2: pure passthrough
    sdr_width = 2'b00; app_req_addr = 30'h100; app_req_len = 9'd2;
    app_req_wr_n = 1'b0; app_sdr_req = 1'b1; app_req_ack_int = 1'b1;
    settle();
    check("w32_addr_int", app_req_addr_int, 32'h100);
    check("w32_len_int", app_req_len_int, 11'd2);
    check("w32_req_int", app_sdr_req_int, 1'b1);
    check("w32_ack", app_req_ack, 1'b1);
    tick();
    app_sdr_req = 1'b0; app_req_ack_int = 1'b0;
    app_wr_data = 32'hCAFEF00D; app_wr_en_n = 4'b0101; app_wr_next_int = 1'b1;
    settle();
    check("w32_next1", app_wr_next, 1'b1);
    check("w32_data", app_wr_data_int, 32'hCAFEF00D);
    check("w32_en", app_wr_en_n_int, 4'b0101);
    tick();
    app_wr_next_int = 1'b0;
    settle();
    check("w32_next0", app_wr_next, 1'b0);
    tick();
    app_wr_next_int = 1'b1;
    settle();
    check("w32_next2", app_wr_next, 1'b1);
    tick();
    app_wr_next_int = 1'b0;

    // 16-bit write, length 2, with busy gating and a mid-burst width change
    sdr_width = 2'b01; app_req_addr = 30'h10; app_req_len = 9'd2; app_req_wr_n = 1'b0;
    settle();
    check("w16_addr_int", app_req_addr_int, 32'h20);
    check("w16_len_int", app_req_len_int, 11'd4);
    ack_req(2'b01, 30'h10, 9'd2, 1'b0);
    app_wr_data = 32'hAABBCCDD; app_wr_en_n = 4'b0000; app_wr_next_int = 1'b1;
    app_sdr_req = 1'b1;
    settle();
    check("w16_busy_req", app_sdr_req_int, 1'b0);
    check("w16_b1_data", app_wr_data_int, 32'h0000CCDD);
    check("w16_b1_en", app_wr_en_n_int, 4'b1100);
    check("w16_b1_next", app_wr_next, 1'b0);
    tick();
    settle();
    check("w16_b2_data", app_wr_data_int, 32'h0000AABB);
    check("w16_b2_next", app_wr_next, 1'b1);
    tick();
    app_wr_data = 32'h11223344; app_wr_en_n = 4'b1000; sdr_width = 2'b10;
    settle();
    check("w16_b3_data", app_wr_data_int, 32'h00003344);
    check("w16_b3_en", app_wr_en_n_int, 4'b1100);
    check("w16_b3_next", app_wr_next, 1'b0);
    tick();
    settle();
    check("w16_b4_data", app_wr_data_int, 32'h00001122);
    check("w16_b4_en", app_wr_en_n_int, 4'b1110);
    check("w16_b4_next", app_wr_next, 1'b1);
    check("w16_b4_busy", app_sdr_req_int, 1'b0);
    tick();
    settle();
    check("w16_idle_req", app_sdr_req_int, 1'b1);
    check("w16_idle_next", app_wr_next, 1'b0);
    app_wr_next_int = 1'b0; app_sdr_req = 1'b0;

    // 8-bit read, length 1; upper beat bits carry junk that must be discarded
    sdr_width = 2'b10; app_req_addr = 30'h40; app_req_len = 9'd1;
    settle();
    check("r8_addr_int", app_req_addr_int, 32'h100);
    check("r8_len_int", app_req_len_int, 11'd4);
    ack_req(2'b10, 30'h40, 9'd1, 1'b1);
    app_rd_valid_int = 1'b1;
    app_rd_data_int = 32'hDEADBE44; settle(); check("r8_v1", app_rd_valid, 1'b0); tick();
    app_rd_data_int = 32'hDEADBE33; settle(); check("r8_v2", app_rd_valid, 1'b0); tick();
    app_rd_data_int = 32'hDEADBE22; settle(); check("r8_v3", app_rd_valid, 1'b0); tick();
    app_rd_data_int = 32'hDEADBE11; settle();
    check("r8_v4", app_rd_valid, 1'b1);
    check("r8_data", app_rd_data, 32'h11223344);
    tick();
    settle();
    check("r8_idle_valid", app_rd_valid, 1'b0);
    app_rd_valid_int = 1'b0;

    // Reset after 3 of 8 beats, then a fresh 16-bit read
    ack_req(2'b10, 30'h0, 9'd2, 1'b1);
    app_rd_valid_int = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    settle();
    check("rst_mid_valid", app_rd_valid, 1'b0);
    tick();
    reset = 1'b0; app_rd_valid_int = 1'b0; app_sdr_req = 1'b1;
    settle();
    check("rst_mid_idle", app_sdr_req_int, 1'b1);
    check("rst_mid_novalid", app_rd_valid, 1'b0);
    ack_req(2'b01, 30'h8, 9'd1, 1'b1);
    app_rd_valid_int = 1'b1;
    app_rd_data_int = 32'h00005678; settle(); check("r16_v1", app_rd_valid, 1'b0); tick();
    app_rd_data_int = 32'hFFFF1234; settle();
    check("r16_v2", app_rd_valid, 1'b1);
    check("r16_data", app_rd_data, 32'h12345678);
    tick();
    app_rd_valid_int = 1'b0;

    // Zero length in 16-bit mode is one word: two beats, one advance
    ack_req(2'b01, 30'h4, 9'd0, 1'b0);
    app_wr_data = 32'h87654321; app_wr_en_n = 4'b0000; app_wr_next_int = 1'b1;
    app_sdr_req = 1'b1;
    settle();
    check("l0_b1_data", app_wr_data_int, 32'h00004321);
    check("l0_b1_next", app_wr_next, 1'b0);
    tick();
    settle();
    check("l0_b2_data", app_wr_data_int, 32'h00008765);
    check("l0_b2_next", app_wr_next, 1'b1);
    tick();
    settle();
    check("l0_idle_req", app_sdr_req_int, 1'b1);
    check("l0_idle_next", app_wr_next, 1'b0);
    app_wr_next_int = 1'b0; app_sdr_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
